// File: rtl/ladybird_sim_axi_memory.sv
// ladybird_sim_axi_memory: simulation-only AXI4 slave backed by sparse byte storage, with a zero-time backdoor.
// Optional decode-error windows are enabled by defining LADYBIRD_SIM_MEMORY_DECERR_EN.
module ladybird_sim_axi_memory #(
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_ID_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  // write address channel
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [AXI_ADDR_W-1:0]     awaddr,
  input  logic [AXI_ID_W-1:0]       awid,
  input  logic [7:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  // write data channel
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [AXI_DATA_W-1:0]     wdata,
  input  logic [AXI_DATA_W/8-1:0]   wstrb,
  input  logic                      wlast,
  // write response channel
  output logic                      bvalid,
  input  logic                      bready,
  output logic [AXI_ID_W-1:0]       bid,
  output logic [1:0]                bresp,
  // read address channel
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [AXI_ADDR_W-1:0]     araddr,
  input  logic [AXI_ID_W-1:0]       arid,
  input  logic [7:0]                arlen,
  input  logic [2:0]                arsize,
  input  logic [1:0]                arburst,
  // read data channel
  output logic                      rvalid,
  input  logic                      rready,
  output logic [AXI_DATA_W-1:0]     rdata,
  output logic [AXI_ID_W-1:0]       rid,
  output logic [1:0]                rresp,
  output logic                      rlast
);

  localparam int unsigned DATA_BYTES = AXI_DATA_W / 8;
  localparam logic [AXI_ADDR_W-1:0] LANE_MASK = AXI_ADDR_W'(DATA_BYTES - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;

`ifdef LADYBIRD_SIM_MEMORY_DECERR_EN
  localparam logic [63:0] CONFROM_BASE    = 64'h0000_1000;
  localparam logic [63:0] CONFROM_SIZE    = 64'h0000_1000;
  localparam logic [63:0] RAM_BASE        = 64'h8000_0000;
  localparam logic [63:0] MEMORY_SIZE_RAM = 64'h4000_0000;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  // Sparse byte storage; absent entries read as zero and reset leaves contents intact.
  logic [7:0] mem [logic [AXI_ADDR_W-1:0]];

  wstate_t               w_state;
  logic [AXI_ADDR_W-1:0] aw_addr_q;
  logic [7:0]            aw_len_q;
  logic [2:0]            aw_size_q;
  logic [1:0]            aw_burst_q;
  logic [7:0]            w_cnt_q;
  logic                  w_first_q;
  logic                  aw_err_q;

  rstate_t               r_state;
  logic [AXI_ADDR_W-1:0] ar_addr_q;
  logic [7:0]            ar_len_q;
  logic [2:0]            ar_size_q;
  logic [1:0]            ar_burst_q;
  logic [7:0]            r_cnt_q;
  logic                  ar_err_q;

  logic [AXI_ADDR_W-1:0] w_next_addr;
  logic [AXI_ADDR_W-1:0] r_next_addr;

  // Burst termination is counted from awlen, so wlast carries no information here.
  logic unused_wlast;
  assign unused_wlast = wlast;

  // Zero-time backdoor write, also the single path through which the bus commits bytes.
  task automatic write(input logic [AXI_ADDR_W-1:0] addr, input logic [7:0] data);
    mem[addr] = data;
  endtask

  function automatic logic [7:0] read(input logic [AXI_ADDR_W-1:0] addr);
    return mem.exists(addr) ? mem[addr] : 8'h00;
  endfunction

  function automatic logic [AXI_ADDR_W-1:0] next_addr(input logic [AXI_ADDR_W-1:0] a,
                                                      input logic [2:0]            size,
                                                      input logic [1:0]            burst);
    if (burst == BURST_FIXED) return a;
    return a + (AXI_ADDR_W'(1) << size);
  endfunction

`ifdef LADYBIRD_SIM_MEMORY_DECERR_EN
  function automatic logic addr_ok(input logic [AXI_ADDR_W-1:0] a);
    logic [63:0] a64;
    a64 = 64'(a);
    return ((a64 >= CONFROM_BASE) && (a64 < CONFROM_BASE + CONFROM_SIZE)) ||
           ((a64 >= RAM_BASE) && (a64 < RAM_BASE + MEMORY_SIZE_RAM));
  endfunction
`else
  function automatic logic addr_ok(input logic [AXI_ADDR_W-1:0] unused_a);
    return 1'b1;
  endfunction
`endif

  // Assemble one beat; on the first beat lanes below the start address stay zero.
  function automatic logic [AXI_DATA_W-1:0] read_beat(input logic [AXI_ADDR_W-1:0] a,
                                                      input logic                  first);
    logic [AXI_DATA_W-1:0] d;
    logic [AXI_ADDR_W-1:0] base;
    logic [7:0]            b;
    int                    off;
    d    = '0;
    base = a & ~LANE_MASK;
    off  = first ? int'(a & LANE_MASK) : 0;
    for (int i = 0; i < int'(DATA_BYTES); i++) begin
      b = (i >= off) ? read(base + AXI_ADDR_W'(i)) : 8'h00;
      d = (d >> 8) | (AXI_DATA_W'(b) << (AXI_DATA_W - 8));
    end
    return d;
  endfunction

  // Commit the strobed lanes of one write beat, honouring the unaligned first-beat rule.
  task automatic commit_beat(input logic [AXI_ADDR_W-1:0] a,
                             input logic                  first,
                             input logic [AXI_DATA_W-1:0] data,
                             input logic [DATA_BYTES-1:0] strb);
    logic [AXI_DATA_W-1:0] d;
    logic [DATA_BYTES-1:0] s;
    logic [AXI_ADDR_W-1:0] base;
    int                    off;
    d    = data;
    s    = strb;
    base = a & ~LANE_MASK;
    off  = first ? int'(a & LANE_MASK) : 0;
    for (int i = 0; i < int'(DATA_BYTES); i++) begin
      if (s[0] && (i >= off)) write(base + AXI_ADDR_W'(i), d[7:0]);
      d = d >> 8;
      s = s >> 1;
    end
  endtask

  assign w_next_addr = next_addr(aw_addr_q, aw_size_q, aw_burst_q);
  assign r_next_addr = next_addr(ar_addr_q, ar_size_q, ar_burst_q);

  // Both channel FSMs share one block: reads are launched before writes commit,
  // so a beat launched on the same edge as a write sees the pre-edge contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state    <= W_IDLE;
      awready    <= 1'b0;
      wready     <= 1'b0;
      bvalid     <= 1'b0;
      bid        <= '0;
      bresp      <= RESP_OKAY;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      w_first_q  <= 1'b0;
      aw_err_q   <= 1'b0;
      r_state    <= R_IDLE;
      arready    <= 1'b0;
      rvalid     <= 1'b0;
      rlast      <= 1'b0;
      rdata      <= '0;
      rid        <= '0;
      rresp      <= RESP_OKAY;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
      ar_err_q   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready    <= 1'b0;
            r_state    <= R_DATA;
            ar_addr_q  <= araddr;
            ar_len_q   <= arlen;
            ar_size_q  <= arsize;
            ar_burst_q <= arburst;
            ar_err_q   <= !addr_ok(araddr);
            r_cnt_q    <= '0;
            rid        <= arid;
            rvalid     <= 1'b1;
            rlast      <= (arlen == 8'd0);
            rresp      <= addr_ok(araddr) ? RESP_OKAY : RESP_DECERR;
            rdata      <= addr_ok(araddr) ? read_beat(araddr, 1'b1) : '0;
          end
        end
        R_DATA: begin
          if (rvalid && rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              ar_addr_q <= r_next_addr;
              r_cnt_q   <= r_cnt_q + 8'd1;
              rlast     <= ((r_cnt_q + 8'd1) == ar_len_q);
              rdata     <= ar_err_q ? '0 : read_beat(r_next_addr, 1'b0);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase

      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            awready    <= 1'b0;
            wready     <= 1'b1;
            w_state    <= W_DATA;
            aw_addr_q  <= awaddr;
            aw_len_q   <= awlen;
            aw_size_q  <= awsize;
            aw_burst_q <= awburst;
            aw_err_q   <= !addr_ok(awaddr);
            w_cnt_q    <= '0;
            w_first_q  <= 1'b1;
            bid        <= awid;
          end
        end
        W_DATA: begin
          if (wvalid && wready) begin
            if (!aw_err_q) commit_beat(aw_addr_q, w_first_q, wdata, wstrb);
            aw_addr_q <= w_next_addr;
            w_first_q <= 1'b0;
            w_cnt_q   <= w_cnt_q + 8'd1;
            if (w_cnt_q == aw_len_q) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= aw_err_q ? RESP_DECERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bvalid && bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ladybird_sim_axi_memory.sv
// Randomized bench for ladybird_sim_axi_memory, checked against a byte-level reference memory.
`timescale 1ns/1ps
module tb_ladybird_sim_axi_memory;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned NB = DW / 8;
  localparam int          TMO = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, rlast;
  logic [AW-1:0] awaddr, araddr;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic [DW-1:0] wdata, rdata;
  logic [NB-1:0] wstrb;

  ladybird_sim_axi_memory #(.AXI_DATA_W(DW), .AXI_ADDR_W(AW), .AXI_ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]    model [logic [31:0]];
  logic [DW-1:0] wd [256];
  logic [NB-1:0] ws [256];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mrd(input logic [31:0] a);
    return model.exists(a) ? model[a] : 8'h00;
  endfunction

  function automatic logic is_err(input logic [31:0] a);
`ifdef LADYBIRD_SIM_MEMORY_DECERR_EN
    return !(((a >= 32'h0000_1000) && (a < 32'h0000_2000)) ||
             ((a >= 32'h8000_0000) && (a < 32'hC000_0000)));
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  // Address of beat i: fixed bursts repeat the start, others step by 2**size.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                            input logic [2:0] sz, input logic [1:0] bt);
    return (bt == 2'b00) ? a : a + 32'(i) * (32'd1 << sz);
  endfunction

  function automatic logic [DW-1:0] exp_beat(input logic [31:0] a, input int i,
                                             input logic [2:0] sz, input logic [1:0] bt);
    logic [31:0] base;
    logic [DW-1:0] e;
    int off;
    base = beat_addr(a, i, sz, bt) & ~32'(NB - 1);
    off  = (i == 0) ? int'(a & 32'(NB - 1)) : 0;
    e    = '0;
    if (!is_err(a))
      for (int j = 0; j < int'(NB); j++)
        if (j >= off) e = e | (DW'(mrd(base + 32'(j))) << (8 * j));
    return e;
  endfunction

  task automatic model_beat(input logic [31:0] a, input int i, input logic [2:0] sz,
                            input logic [1:0] bt, input logic [DW-1:0] d, input logic [NB-1:0] s);
    logic [31:0] base;
    int off;
    base = beat_addr(a, i, sz, bt) & ~32'(NB - 1);
    off  = (i == 0) ? int'(a & 32'(NB - 1)) : 0;
    if (!is_err(a))
      for (int j = 0; j < int'(NB); j++)
        if ((j >= off) && (((s >> j) & NB'(1)) != '0)) model[base + 32'(j)] = 8'(d >> (8 * j));
  endtask

  task automatic bd_write(input logic [31:0] a, input logic [7:0] d);
    dut.write(a, d);
    model[a] = d;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [IW-1:0] id, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bt, input int bhold, input bit gaps);
    int t;
    @(negedge clk);
    awvalid = 1'b1; awaddr = a; awid = id; awlen = len; awsize = sz; awburst = bt;
    t = 0;
    while (!awready && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) check("aw_timeout", 64'(t), 64'(0));
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge clk); end
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == int'(len));
      t = 0;
      while (!wready && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) check("w_timeout", 64'(t), 64'(0));
      model_beat(a, i, sz, bt, wd[i], ws[i]);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("b_valid", 64'(bvalid), 64'd1);
    for (int k = 0; k < bhold; k++) begin
      @(negedge clk);
      check("b_hold", 64'(bvalid), 64'd1);
    end
    bready = 1'b1;
    check("bid", 64'(bid), 64'(id));
    check("bresp", 64'(bresp), is_err(a) ? 64'd3 : 64'd0);
    @(negedge clk);
    bready = 1'b0;
    check("b_done", 64'(bvalid), 64'd0);
    check("awready_after_b", 64'(awready), 64'd1);
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [IW-1:0] id, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bt, input int hold, input bit rnd);
    int t;
    int i;
    int cyc;
    @(negedge clk);
    arvalid = 1'b1; araddr = a; arid = id; arlen = len; arsize = sz; arburst = bt;
    t = 0;
    while (!arready && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) check("ar_timeout", 64'(t), 64'(0));
    @(negedge clk);
    arvalid = 1'b0;
    check("r_first_valid", 64'(rvalid), 64'd1);
    i = 0;
    cyc = 0;
    while (i <= int'(len) && cyc < TMO * 4) begin
      rready = (cyc < hold) ? 1'b0 : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      if (rvalid) begin
        check("rdata", 64'(rdata), 64'(exp_beat(a, i, sz, bt)));
        check("rlast", 64'(rlast), 64'(i == int'(len)));
        check("rid", 64'(rid), 64'(id));
        check("rresp", 64'(rresp), is_err(a) ? 64'd3 : 64'd0);
        if (rready) i++;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= TMO * 4) check("r_timeout", 64'(cyc), 64'(0));
    rready = 1'b0;
    check("r_done", 64'(rvalid), 64'd0);
  endtask

  task automatic fill(input int n, input bit full_strb);
    for (int i = 0; i < n; i++) begin
      wd[i] = DW'($urandom);
      ws[i] = full_strb ? '1 : NB'($urandom);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int t;
    rst = 1'b1;
    awvalid = 0; awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0;
    wvalid = 0; wdata = '0; wstrb = '0; wlast = 0; bready = 0;
    arvalid = 0; araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0; rready = 0;
    repeat (2) @(negedge clk);
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_resp", 64'({bresp, rresp}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_awready", 64'(awready), 64'd1);
    check("idle_arready", 64'(arready), 64'd1);

    // Boot word via backdoor, then a single-beat read.
    bd_write(32'h8000_0000, 8'h13); bd_write(32'h8000_0001, 8'h00);
    bd_write(32'h8000_0002, 8'h00); bd_write(32'h8000_0003, 8'h73);
    check("bd_read", 64'(dut.read(32'h8000_0003)), 64'h73);
    check("boot_word_model", 64'(exp_beat(32'h8000_0000, 0, 3'd2, 2'b01)), 64'h7300_0013);
    axi_read(32'h8000_0000, 4'd1, 8'd0, 3'd2, 2'b01, 0, 1'b0);

    // Four-word INCR write then read-back.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h1111_1111 * 32'(i + 1); ws[i] = '1; end
    axi_write(32'h8000_0100, 4'd5, 8'd3, 3'd2, 2'b01, 2, 1'b0);
    axi_read(32'h8000_0100, 4'd6, 8'd3, 3'd2, 2'b01, 0, 1'b0);

    // Partial strobe.
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    axi_write(32'h8000_0200, 4'd2, 8'd0, 3'd2, 2'b01, 0, 1'b0);
    check("strb_model", 64'(exp_beat(32'h8000_0200, 0, 3'd2, 2'b01)), 64'h00BB_00DD);
    axi_read(32'h8000_0200, 4'd2, 8'd0, 3'd2, 2'b01, 0, 1'b0);

    // rready stalled for three cycles on a two-beat read.
    axi_read(32'h8000_0100, 4'd7, 8'd1, 3'd2, 2'b01, 3, 1'b0);

    // Never-written location and out-of-window address.
    axi_read(32'h9000_0000, 4'd3, 8'd0, 3'd2, 2'b01, 0, 1'b0);
    wd[0] = 32'hCAFE_F00D; ws[0] = '1;
    axi_write(32'h4000_0000, 4'd4, 8'd0, 3'd2, 2'b01, 0, 1'b0);
    axi_read(32'h4000_0000, 4'd4, 8'd0, 3'd2, 2'b01, 0, 1'b0);

    // Unaligned start: first-beat lanes below the start are untouched.
    fill(2, 1'b1);
    axi_write(32'h8000_0402, 4'd8, 8'd1, 3'd2, 2'b01, 0, 1'b0);
    axi_read(32'h8000_0401, 4'd8, 8'd2, 3'd2, 2'b01, 0, 1'b1);

    // Simultaneous AW and AR on disjoint regions.
    fill(3, 1'b0);
    fork
      axi_write(32'h8000_0300, 4'd9, 8'd2, 3'd2, 2'b01, 1, 1'b1);
      axi_read(32'h8000_0100, 4'd10, 8'd3, 3'd2, 2'b00, 0, 1'b1);
    join

    // Randomized traffic over a small overlapping window.
    for (int n = 0; n < 60; n++) begin
      a = 32'h8000_0000 + 32'($urandom_range(0, 127));
      case ($urandom_range(0, 4))
        0: bd_write(a, 8'($urandom));
        1, 2: begin
          fill(8, $urandom_range(0, 1) == 1);
          axi_write(a, IW'($urandom), 8'($urandom_range(0, 5)), 3'($urandom_range(0, 2)),
                    2'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b1);
        end
        default:
          axi_read(a, IW'($urandom), 8'($urandom_range(0, 5)), 3'($urandom_range(0, 2)),
                   2'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b1);
      endcase
    end

    // Reset in the middle of a write burst: two beats land, no response follows.
    fill(4, 1'b1);
    @(negedge clk);
    awvalid = 1'b1; awaddr = 32'h8000_0500; awid = 4'd3; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01;
    t = 0;
    while (!awready && t < TMO) begin @(negedge clk); t++; end
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = 1'b0;
      t = 0;
      while (!wready && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) check("rst_w_timeout", 64'(t), 64'(0));
      model_beat(32'h8000_0500, i, 3'd2, 2'b01, wd[i], ws[i]);
      @(negedge clk);
    end
    rst = 1'b1;
    wvalid = 1'b0;
    #1;
    check("midrst_bvalid", 64'(bvalid), 64'd0);
    check("midrst_wready", 64'(wready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_awready", 64'(awready), 64'd1);
    check("postrst_bvalid", 64'(bvalid), 64'd0);
    check("postrst_wready", 64'(wready), 64'd0);

    // Full sweep of the touched region through the backdoor.
    for (int k = 0; k < 32'h540; k++)
      check("sweep", 64'(dut.read(32'h8000_0000 + 32'(k))), 64'(mrd(32'h8000_0000 + 32'(k))));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
